pid_pwm: RTL

- Downstream output stage for the pid block: consumes pid out/out_valid (signed Q_BITS fixed point) and drives a complementary PWM pair with programmable period and deadtime.
- Clamps the PID output to [0, 1.0] and scales it to a duty count.
- Double-buffers duty so updates land only at period boundaries.
- Emits period_start each period; top level ties it to pid iterate_enable so control updates stay synchronous to the PWM carrier.

---
 rtl/pid_pwm_if.sv | 39 +++
 rtl/pid_pwm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pwm_if
//  Purpose  : Bundles the register bus, the pid controller output and the
//             complementary PWM outputs of pid_pwm into a single interface.
//  Signals  : write_enable  active-low register write strobe
//             reg_addr      register address
//             reg_data      register write data
//             pid_out       signed fixed-point controller output
//             pid_valid     single-cycle pid_out valid pulse
//             pwm_hi        high-side gate drive
//             pwm_lo        low-side gate drive
//             period_start  one-cycle pulse at carrier count 0 while enabled
//  Modports : master drives bus/pid inputs, slave is the pid_pwm side
//  Revision : 1.0  initial release
// ============================================================================
interface pid_pwm_if #(
    parameter int D_WIDTH = 16
);
    logic               write_enable;
    logic [D_WIDTH-1:0] reg_addr;
    logic [D_WIDTH-1:0] reg_data;
    logic [D_WIDTH-1:0] pid_out;
    logic               pid_valid;
    logic               pwm_hi;
    logic               pwm_lo;
    logic               period_start;

    modport master (
        output write_enable, reg_addr, reg_data, pid_out, pid_valid,
        input  pwm_hi, pwm_lo, period_start
    );

    modport slave (
        input  write_enable, reg_addr, reg_data, pid_out, pid_valid,
        output pwm_hi, pwm_lo, period_start
    );
endinterface
`default_nettype wire

// File: rtl/pid_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pwm
//  Purpose  : PWM output stage for the pid controller. Clamps pid_out to
//             [0, 1.0], scales it to a duty count against the active period,
//             double-buffers the duty so it changes only at period boundaries
//             and drives a complementary hi/lo pair with programmable
//             deadtime. period_start marks the start of every carrier period.
//  Ports    : clk   system clock, rising edge
//             rstb  asynchronous active-low reset
//             bus   pid_pwm_if.slave (register bus, pid input, PWM outputs)
//  Registers: addr 0 PERIOD (min 2), addr 1 DEADTIME, addr 2 CTRL (bit0 enable)
//  Revision : 1.0  initial release
// ============================================================================
module pid_pwm #(
    parameter int D_WIDTH   = 16,
    parameter int Q_BITS    = 13,
    parameter int CNT_WIDTH = 16
) (
    input  wire        clk,
    input  wire        rstb,
    pid_pwm_if.slave   bus
);
    localparam int                     c_PROD_W     = CNT_WIDTH + Q_BITS;
    localparam logic [CNT_WIDTH-1:0]   c_PERIOD_RST = CNT_WIDTH'(1000);
    localparam logic [CNT_WIDTH-1:0]   c_PERIOD_MIN = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE    = CNT_WIDTH'(1);
    localparam logic signed [D_WIDTH-1:0] c_ONE_S   = D_WIDTH'(1 << Q_BITS);

    localparam logic [1:0] c_ST_OFF  = 2'd0;
    localparam logic [1:0] c_ST_HI   = 2'd1;
    localparam logic [1:0] c_ST_LO   = 2'd2;
    localparam logic [1:0] c_ST_DEAD = 2'd3;

    // Shadow and active configuration
    logic [CNT_WIDTH-1:0] r_period_sh;
    logic [CNT_WIDTH-1:0] r_deadtime_sh;
    logic [CNT_WIDTH-1:0] r_period_act;
    logic [CNT_WIDTH-1:0] r_deadtime_act;
    logic                 r_enable;

    // Duty pipeline
    logic [Q_BITS:0]      r_clamped;
    logic                 r_clamped_vld;
    logic [CNT_WIDTH-1:0] r_duty_sh;
    logic [CNT_WIDTH-1:0] r_duty_act;

    // Carrier and deadtime FSM
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_dead_cnt;
    logic [1:0]           r_state;
    logic                 r_pwm_hi;
    logic                 r_pwm_lo;
    logic                 r_period_start;

    logic                 w_wr_period;
    logic                 w_wr_dead;
    logic                 w_wr_ctrl;
    logic [CNT_WIDTH-1:0] w_wr_val;
    logic                 w_en_next;
    logic                 w_wrap;
    logic                 w_load;
    logic                 w_raw;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [1:0]           w_state_next;
    logic [CNT_WIDTH-1:0] w_dead_cnt_next;
    logic signed [D_WIDTH-1:0] w_pid_s;
    logic [Q_BITS:0]      w_clamp;
    logic [CNT_WIDTH-1:0] w_duty_scaled;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    assign w_wr_period = ~bus.write_enable && (bus.reg_addr == D_WIDTH'(0));
    assign w_wr_dead   = ~bus.write_enable && (bus.reg_addr == D_WIDTH'(1));
    assign w_wr_ctrl   = ~bus.write_enable && (bus.reg_addr == D_WIDTH'(2));
    assign w_wr_val    = CNT_WIDTH'(bus.reg_data);

    // CTRL takes effect on the write edge itself, so every decision below
    // that depends on "enabled after this edge" uses w_en_next.
    assign w_en_next   = w_wr_ctrl ? bus.reg_data[0] : r_enable;

    // ------------------------------------------------------------------
    // Duty scaling: clamp to [0, 1.0], then scale by the active period.
    // The product is < 2^(Q_BITS+CNT_WIDTH) because the clamped value is
    // at most 1<<Q_BITS, so the shifted result always fits CNT_WIDTH.
    // ------------------------------------------------------------------
    assign w_pid_s = $signed(bus.pid_out);

    always_comb begin
        w_clamp = '0;
        if (w_pid_s[D_WIDTH-1]) begin
            w_clamp = '0;
        end else if (w_pid_s > c_ONE_S) begin
            w_clamp = {1'b1, {Q_BITS{1'b0}}};
        end else begin
            w_clamp = w_pid_s[Q_BITS:0];
        end
    end

    assign w_duty_scaled = CNT_WIDTH'((c_PROD_W'(r_clamped) * c_PROD_W'(r_period_act)) >> Q_BITS);

    // ------------------------------------------------------------------
    // Carrier
    // ------------------------------------------------------------------
    assign w_raw  = (r_cnt < r_duty_act);
    assign w_wrap = r_enable && (r_cnt == (r_period_act - c_CNT_ONE));
    // Actives reload at every wrap and when enable rises.
    assign w_load = w_wrap || (~r_enable && w_en_next);

    always_comb begin
        w_cnt_next = r_cnt + c_CNT_ONE;
        if (!w_en_next || !r_enable || w_wrap) begin
            w_cnt_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Deadtime FSM next state. Both sides are driven only from the HI/LO
    // states, so the pair can never be high together.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_dead_cnt_next = r_dead_cnt;
        if (!r_enable || !w_en_next) begin
            w_state_next    = c_ST_OFF;
            w_dead_cnt_next = '0;
        end else begin
            case (r_state)
                c_ST_OFF: begin
                    w_state_next = w_raw ? c_ST_HI : c_ST_LO;
                end
                c_ST_HI: begin
                    if (!w_raw) begin
                        if (r_deadtime_act == '0) begin
                            w_state_next = c_ST_LO;
                        end else begin
                            w_state_next    = c_ST_DEAD;
                            w_dead_cnt_next = r_deadtime_act;
                        end
                    end
                end
                c_ST_LO: begin
                    if (w_raw) begin
                        if (r_deadtime_act == '0) begin
                            w_state_next = c_ST_HI;
                        end else begin
                            w_state_next    = c_ST_DEAD;
                            w_dead_cnt_next = r_deadtime_act;
                        end
                    end
                end
                default: begin
                    // Counter holds the remaining dead cycles including the
                    // current one; the exit side is picked from raw now.
                    if (r_dead_cnt <= c_CNT_ONE) begin
                        w_state_next    = w_raw ? c_ST_HI : c_ST_LO;
                        w_dead_cnt_next = '0;
                    end else begin
                        w_dead_cnt_next = r_dead_cnt - c_CNT_ONE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_period_sh    <= c_PERIOD_RST;
            r_deadtime_sh  <= '0;
            r_period_act   <= c_PERIOD_RST;
            r_deadtime_act <= '0;
            r_enable       <= 1'b0;
            r_clamped      <= '0;
            r_clamped_vld  <= 1'b0;
            r_duty_sh      <= '0;
            r_duty_act     <= '0;
            r_cnt          <= '0;
            r_dead_cnt     <= '0;
            r_state        <= c_ST_OFF;
            r_pwm_hi       <= 1'b0;
            r_pwm_lo       <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            if (w_wr_period) begin
                r_period_sh <= (w_wr_val < c_PERIOD_MIN) ? c_PERIOD_MIN : w_wr_val;
            end
            if (w_wr_dead) begin
                r_deadtime_sh <= w_wr_val;
            end
            r_enable <= w_en_next;

            r_clamped_vld <= bus.pid_valid;
            if (bus.pid_valid) begin
                r_clamped <= w_clamp;
            end
            if (r_clamped_vld) begin
                r_duty_sh <= w_duty_scaled;
            end

            // A shadow duty landing on the wrap edge is not seen here
            // (old value sampled) and goes out one period later.
            if (w_load) begin
                r_period_act   <= r_period_sh;
                r_deadtime_act <= r_deadtime_sh;
                r_duty_act     <= r_duty_sh;
            end

            r_cnt          <= w_cnt_next;
            r_state        <= w_state_next;
            r_dead_cnt     <= w_dead_cnt_next;
            r_pwm_hi       <= (w_state_next == c_ST_HI);
            r_pwm_lo       <= (w_state_next == c_ST_LO);
            r_period_start <= w_en_next && (w_cnt_next == '0);
        end
    end

    assign bus.pwm_hi       = r_pwm_hi;
    assign bus.pwm_lo       = r_pwm_lo;
    assign bus.period_start = r_period_start;

endmodule
`default_nettype wire
